// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO write-port arbiter: FSM state encoding and the HI/LO field layout.
package hilo_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } hl_state_t;

    localparam int         HL_HI_MSB    = 63;
    localparam int         HL_LO_MSB    = 31;
    localparam logic [7:0] DROP_CNT_MAX = 8'hFF;

endpackage

// File: rtl/hilo_port_arbiter.sv
// Shares the HI/LO write port between WB and the divider; a divide result is granted 1+ cycles after div_valid.
// WB always wins the port; the buffered result waits in HOLD, and ID is stalled on HI/LO access while a divide is outstanding.
module hilo_port_arbiter
    import hilo_pkg::*;
#(
    parameter int HL_W = HL_HI_MSB + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            div_start,
    input  logic            div_valid,
    input  logic [HL_W-1:0] div_result,
    input  logic            pipe_flush,
    input  logic            id_hl_access,
    input  logic            wb_hl_we,
    input  logic [HL_W-1:0] wb_hl_data,
    output logic            hl_write_enable_from_wb,
    output logic [HL_W-1:0] hl_data,
    output logic            hl_stall,
    output logic            div_busy,
    output logic [7:0]      div_drop_cnt
);

    hl_state_t       state_q, state_d;
    logic [HL_W-1:0] hl_buf_q, hl_buf_d;
    logic [7:0]      drop_cnt_q, drop_cnt_d;
    logic            drop_evt;
    logic            grant;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            hl_buf_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hl_buf_q   <= hl_buf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hl_buf_d   = hl_buf_q;
        drop_cnt_d = drop_cnt_q;
        drop_evt   = 1'b0;
        case (state_q)
            IDLE: begin
                if (div_start && !pipe_flush) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // A flush coinciding with the result kills it outright; no HOLD detour.
                if (div_valid && pipe_flush) begin
                    state_d  = IDLE;
                    drop_evt = 1'b1;
                end else if (div_valid) begin
                    state_d  = HOLD;
                    hl_buf_d = div_result;
                end else if (pipe_flush) begin
                    state_d = DISCARD;
                end
            end
            HOLD: begin
                // The divide is older than anything a flush removes, so only WB can delay it.
                if (!wb_hl_we) begin
                    state_d = IDLE;
                end
            end
            DISCARD: begin
                if (div_valid) begin
                    state_d  = IDLE;
                    drop_evt = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (drop_evt && (drop_cnt_q != DROP_CNT_MAX)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // Outputs are forced low while rst is asserted, including the registered views.
    always_comb begin
        grant                   = 1'b0;
        hl_write_enable_from_wb = 1'b0;
        hl_data                 = '0;
        hl_stall                = 1'b0;
        div_busy                = 1'b0;
        div_drop_cnt            = '0;
        if (rst) begin
            grant                   = (state_q == HOLD) && !wb_hl_we;
            hl_write_enable_from_wb = wb_hl_we | grant;
            hl_data                 = wb_hl_we ? wb_hl_data : hl_buf_q;
            hl_stall                = id_hl_access && (state_q != IDLE);
            div_busy                = (state_q != IDLE);
            div_drop_cnt            = drop_cnt_q;
        end
    end

endmodule
